// File: rtl/rs_enc_lfsr.sv
// Byte-serial systematic RS(n, n-4) encoder over GF(2^8), poly 0x11D, roots alpha^0..alpha^3.
// Message bytes pass through; four parity bytes from a 4-stage LFSR follow the eop byte.
module rs_enc_lfsr (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic       in_eop,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_par,
    output logic [7:0] out_data
);

    localparam logic [7:0] G3 = 8'h0F;
    localparam logic [7:0] G2 = 8'h36;
    localparam logic [7:0] G1 = 8'h78;
    localparam logic [7:0] G0 = 8'h40;

    typedef enum logic [2:0] {
        StIdle   = 3'b001,
        StData   = 3'b010,
        StParity = 3'b100
    } state_e;

    // Shift-and-add multiply reduced by 0x11D; with a constant operand this folds to XORs.
    function automatic logic [7:0] gf2m8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[7] ? ((sh << 1) ^ 8'h1D) : (sh << 1);
        end
        return acc;
    endfunction

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] p0_q, p0_d;
    logic [7:0] p1_q, p1_d;
    logic [7:0] p2_q, p2_d;
    logic [7:0] p3_q, p3_d;

    logic       ready_q, ready_d;
    logic       ovalid_q, ovalid_d;
    logic       osop_q, osop_d;
    logic       oeop_q, oeop_d;
    logic       opar_q, opar_d;
    logic [7:0] odata_q, odata_d;

    logic       accept;
    logic       take_byte;
    logic [7:0] fb;
    logic [7:0] carry0, carry1, carry2;

    assign accept = in_valid & ready_q;
    // Outside a message only a sop byte may start one; stray bytes are dropped silently.
    assign take_byte = accept & (in_sop | (state_q == StData));

    // A sop byte restarts the division, so the old partial remainder is ignored.
    assign fb     = in_data ^ (in_sop ? 8'h00 : p3_q);
    assign carry0 = in_sop ? 8'h00 : p0_q;
    assign carry1 = in_sop ? 8'h00 : p1_q;
    assign carry2 = in_sop ? 8'h00 : p2_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        p3_d     = p3_q;
        ovalid_d = 1'b0;
        osop_d   = 1'b0;
        oeop_d   = 1'b0;
        opar_d   = 1'b0;
        odata_d  = 8'h00;

        unique case (state_q)
            StIdle, StData: begin
                if (take_byte) begin
                    p3_d     = carry2 ^ gf2m8_mul(fb, G3);
                    p2_d     = carry1 ^ gf2m8_mul(fb, G2);
                    p1_d     = carry0 ^ gf2m8_mul(fb, G1);
                    p0_d     = gf2m8_mul(fb, G0);
                    ovalid_d = 1'b1;
                    osop_d   = in_sop;
                    odata_d  = in_data;
                    cnt_d    = 2'd0;
                    state_d  = in_eop ? StParity : StData;
                end
            end
            StParity: begin
                ovalid_d = 1'b1;
                opar_d   = 1'b1;
                odata_d  = p3_q;
                p3_d     = p2_q;
                p2_d     = p1_q;
                p1_d     = p0_q;
                p0_d     = 8'h00;
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    oeop_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d != StParity);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            cnt_q    <= 2'd0;
            p0_q     <= 8'h00;
            p1_q     <= 8'h00;
            p2_q     <= 8'h00;
            p3_q     <= 8'h00;
            ready_q  <= 1'b1;
            ovalid_q <= 1'b0;
            osop_q   <= 1'b0;
            oeop_q   <= 1'b0;
            opar_q   <= 1'b0;
            odata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            ready_q  <= ready_d;
            ovalid_q <= ovalid_d;
            osop_q   <= osop_d;
            oeop_q   <= oeop_d;
            opar_q   <= opar_d;
            odata_q  <= odata_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = ovalid_q;
    assign out_sop   = osop_q;
    assign out_eop   = oeop_q;
    assign out_par   = opar_q;
    assign out_data  = odata_q;

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Randomised scoreboard bench for rs_enc_lfsr: reference parity by polynomial long division,
// plus a syndrome check of every codeword the encoder emits.
module tb_rs_enc_lfsr;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic       in_eop = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       out_par;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    rs_enc_lfsr dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .in_eop   (in_eop),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_par  (out_par),
        .out_data (out_data)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       par;
        logic       eop;
    } exp_t;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] gexp[256];
    int         glog[256];
    exp_t       exp_q[$];
    logic [7:0] cur_msg[$];
    bit         in_msg = 1'b0;
    logic [7:0] mon_cw[$];
    logic [7:0] last_cw[$];

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endfunction

    function automatic void build_tables();
        logic [8:0] x;
        x = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x[7:0];
            glog[x[7:0]] = i;
            x = x << 1;
            if (x[8]) x = x ^ 9'h11D;
        end
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    // Remainder of m(x)*x^4 divided by g(x); returns {x^3, x^2, x^1, x^0} coefficients.
    function automatic logic [31:0] rs_parity(input logic [7:0] msg[$]);
        logic [7:0] c[$];
        logic [7:0] g[5];
        logic [7:0] coef;
        int         k;
        g = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
        c = msg;
        k = msg.size();
        repeat (4) c.push_back(8'h00);
        for (int i = 0; i < k; i++) begin
            coef = c[i];
            for (int j = 1; j <= 4; j++) c[i + j] = c[i + j] ^ gmul(coef, g[j]);
        end
        return {c[k], c[k + 1], c[k + 2], c[k + 3]};
    endfunction

    // Message-level model of one accepted byte; returns 1 when parity follows.
    function automatic bit model_accept(input logic [7:0] d, input bit sop, input bit eop);
        logic [31:0] par;
        if (sop) begin
            cur_msg = {};
            in_msg  = 1'b1;
        end
        if (!in_msg) return 1'b0;
        cur_msg.push_back(d);
        exp_q.push_back('{data: d, sop: sop, par: 1'b0, eop: 1'b0});
        if (!eop) return 1'b0;
        par = rs_parity(cur_msg);
        exp_q.push_back('{data: par[31:24], sop: 1'b0, par: 1'b1, eop: 1'b0});
        exp_q.push_back('{data: par[23:16], sop: 1'b0, par: 1'b1, eop: 1'b0});
        exp_q.push_back('{data: par[15:8],  sop: 1'b0, par: 1'b1, eop: 1'b0});
        exp_q.push_back('{data: par[7:0],   sop: 1'b0, par: 1'b1, eop: 1'b1});
        in_msg = 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] s;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_sop_par_eop", {out_sop, out_par, out_eop}, {e.sop, e.par, e.eop});
            end
            if (out_sop) mon_cw = {};
            mon_cw.push_back(out_data);
            if (out_eop) begin
                last_cw = mon_cw;
                for (int j = 0; j < 4; j++) begin
                    s = 8'h00;
                    foreach (mon_cw[i]) s = gmul(s, gexp[j]) ^ mon_cw[i];
                    check($sformatf("syndrome_S%0d", j), s, 8'h00);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_random(input bit en);
        in_valid = en;
        in_sop   = 1'($urandom);
        in_eop   = 1'($urandom);
        in_data  = 8'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input bit sop, input bit eop, input int gap,
                        input bit poke, input bit rdy_chk);
        int wait_cnt;
        bit par;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_data  = d;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        par = model_accept(d, sop, eop);
        #1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        if (par && rdy_chk) begin
            check("in_ready_low_p1", in_ready, 1'b0);
            for (int i = 2; i <= 4; i++) begin
                poke_random(poke);
                tick();
                check($sformatf("in_ready_low_p%0d", i), in_ready, 1'b0);
            end
            poke_random(poke);
            tick();
            in_valid = 1'b0;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
            check("in_ready_back_high", in_ready, 1'b1);
        end
    endtask

    task automatic send_msg(input logic [7:0] m[$], input int max_gap, input bit poke);
        for (int i = 0; i < m.size(); i++) begin
            send(m[i], i == 0, i == m.size() - 1, $urandom_range(0, max_gap), poke, 1'b1);
        end
    endtask

    task automatic check_last(input string name, input int len, input logic [31:0] par);
        tick();
        check({name, "_len"}, last_cw.size(), len + 4);
        if (last_cw.size() == len + 4) begin
            check({name, "_parity"},
                  {last_cw[len], last_cw[len + 1], last_cw[len + 2], last_cw[len + 3]}, par);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m[$];
        build_tables();

        rstn = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_flags", {out_valid, out_sop, out_eop, out_par}, 4'b0000);
        check("rst_out_data", out_data, 8'h00);
        rstn = 1'b1;
        tick();

        m = '{8'h01};
        send_msg(m, 0, 1'b0);
        check_last("single_01", 1, 32'h0F367840);

        m = '{8'h00, 8'h01};
        send_msg(m, 1, 1'b0);
        check_last("msg_00_01", 2, 32'h0F367840);

        m = {};
        repeat (251) m.push_back(8'h00);
        send_msg(m, 0, 1'b0);
        check_last("zeros_251", 251, 32'h00000000);

        // Back-to-back random codewords with random gaps and pokes during parity.
        for (int n = 0; n < 10; n++) begin
            m = {};
            repeat ((n == 0) ? 251 : $urandom_range(1, 251)) m.push_back(8'($urandom));
            send_msg(m, (n < 3) ? 0 : 2, 1'($urandom));
        end

        // Stray bytes outside a message, then a message aborted by a fresh sop.
        send(8'hAA, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        send(8'h55, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        send(8'h11, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 1'b0, 1, 1'b0, 1'b1);
        m = '{8'h12, 8'h34, 8'h56};
        send_msg(m, 1, 1'b1);
        tick();

        // Reset during the second parity byte.
        send(8'h01, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        tick();
        tick();
        rstn = 1'b0;
        tick();
        exp_q.delete();
        in_msg = 1'b0;
        check("midrst_out_flags", {out_valid, out_sop, out_eop, out_par}, 4'b0000);
        check("midrst_out_data", out_data, 8'h00);
        check("midrst_in_ready", in_ready, 1'b1);
        rstn = 1'b1;
        tick();
        m = '{8'h01};
        send_msg(m, 0, 1'b0);
        check_last("after_rst_01", 1, 32'h0F367840);

        repeat (10) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
